// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, final result select, register-file
// write port, forwarding qualifier and retired-instruction counter.
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             valid_m,
  input  logic             reg_write_m,
  input  logic [1:0]       result_src_m,
  input  logic [4:0]       rd_m,
  input  logic [XLEN-1:0]  alu_result_m,
  input  logic [XLEN-1:0]  read_data_m,
  input  logic [XLEN-1:0]  pc_plus4_m,
  input  logic             instret_clr,
  output logic             write_en_w,
  output logic [4:0]       rd_w,
  output logic [XLEN-1:0]  result_w,
  output logic             fwd_valid_w,
  output logic             retire_w,
  output logic [CNT_W-1:0] instret
);

  logic             valid_q,      valid_d;
  logic             reg_write_q,  reg_write_d;
  logic [1:0]       result_src_q, result_src_d;
  logic [4:0]       rd_q,         rd_d;
  logic [XLEN-1:0]  alu_result_q, alu_result_d;
  logic [XLEN-1:0]  read_data_q,  read_data_d;
  logic [XLEN-1:0]  pc_plus4_q,   pc_plus4_d;
  logic             fresh_q,      fresh_d;
  logic [CNT_W-1:0] instret_q,    instret_d;

  logic             retire_s;
  logic             fwd_valid_s;

  // W register next state: flush beats stall beats normal capture
  always_comb begin
    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    result_src_d = result_src_q;
    rd_d         = rd_q;
    alu_result_d = alu_result_q;
    read_data_d  = read_data_q;
    pc_plus4_d   = pc_plus4_q;
    fresh_d      = 1'b0;
    if (flush) begin
      valid_d      = 1'b0;
      reg_write_d  = 1'b0;
      result_src_d = 2'b00;
      rd_d         = 5'd0;
      alu_result_d = '0;
      read_data_d  = '0;
      pc_plus4_d   = '0;
      fresh_d      = 1'b0;
    end else if (stall) begin
      fresh_d      = 1'b0;
    end else begin
      valid_d      = valid_m;
      reg_write_d  = reg_write_m;
      result_src_d = result_src_m;
      rd_d         = rd_m;
      alu_result_d = alu_result_m;
      read_data_d  = read_data_m;
      pc_plus4_d   = pc_plus4_m;
      fresh_d      = 1'b1;
    end
  end

  // A W entry retires only in the first cycle after it was captured
  always_comb begin
    retire_s    = valid_q & fresh_q;
    fwd_valid_s = valid_q & reg_write_q & (rd_q != 5'd0);
  end

  // Counter clear wins over the increment of a coinciding retirement
  always_comb begin
    instret_d = instret_q;
    if (instret_clr) begin
      instret_d = '0;
    end else if (retire_s) begin
      instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      instret_d = instret_q;
    end
  end

  // Pipeline register and counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      result_src_q <= 2'b00;
      rd_q         <= 5'd0;
      alu_result_q <= '0;
      read_data_q  <= '0;
      pc_plus4_q   <= '0;
      fresh_q      <= 1'b0;
      instret_q    <= '0;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      result_src_q <= result_src_d;
      rd_q         <= rd_d;
      alu_result_q <= alu_result_d;
      read_data_q  <= read_data_d;
      pc_plus4_q   <= pc_plus4_d;
      fresh_q      <= fresh_d;
      instret_q    <= instret_d;
    end
  end

  // Outputs depend only on W flops, never on the _m inputs
  always_comb begin
    case (result_src_q)
      2'b00:   result_w = alu_result_q;
      2'b01:   result_w = read_data_q;
      2'b10:   result_w = pc_plus4_q;
      default: result_w = '0;
    endcase
    rd_w        = rd_q;
    fwd_valid_w = fwd_valid_s;
    write_en_w  = fwd_valid_s & fresh_q;
    retire_w    = retire_s;
    instret     = instret_q;
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a slot-level reference model.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, valid_m, reg_write_m, instret_clr;
  logic [1:0]  result_src_m;
  logic [4:0]  rd_m;
  logic [31:0] alu_result_m, read_data_m, pc_plus4_m;
  logic        write_en_w, fwd_valid_w, retire_w;
  logic [4:0]  rd_w;
  logic [31:0] result_w;
  logic [63:0] instret;

  logic        s_we, s_fwd, s_ret;
  logic [4:0]  s_rd;
  logic [7:0]  s_res;
  logic [2:0]  s_instret;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_m(valid_m),
    .reg_write_m(reg_write_m), .result_src_m(result_src_m), .rd_m(rd_m),
    .alu_result_m(alu_result_m), .read_data_m(read_data_m), .pc_plus4_m(pc_plus4_m),
    .instret_clr(instret_clr), .write_en_w(write_en_w), .rd_w(rd_w),
    .result_w(result_w), .fwd_valid_w(fwd_valid_w), .retire_w(retire_w),
    .instret(instret)
  );

  // Narrow instance so counter wrap-around is reachable in a few cycles
  wb_stage #(.XLEN(8), .CNT_W(3)) u_small (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_m(valid_m),
    .reg_write_m(reg_write_m), .result_src_m(result_src_m), .rd_m(rd_m),
    .alu_result_m(alu_result_m[7:0]), .read_data_m(read_data_m[7:0]),
    .pc_plus4_m(pc_plus4_m[7:0]), .instret_clr(instret_clr), .write_en_w(s_we),
    .rd_w(s_rd), .result_w(s_res), .fwd_valid_w(s_fwd), .retire_w(s_ret),
    .instret(s_instret)
  );

  // Reference model: the instruction sitting in W and whether it was already reported
  typedef struct {
    logic        valid;
    logic        rw;
    logic [1:0]  src;
    logic [4:0]  rd;
    logic [31:0] alu, rdata, pc4;
  } slot_t;
  slot_t       m_slot;
  logic        m_reported;
  logic [63:0] m_cnt;

  function automatic logic [31:0] m_result();
    if (m_slot.src == 2'd0) return m_slot.alu;
    if (m_slot.src == 2'd1) return m_slot.rdata;
    if (m_slot.src == 2'd2) return m_slot.pc4;
    return 32'd0;
  endfunction
  function automatic logic m_fwd();
    return m_slot.valid && m_slot.rw && (m_slot.rd != 5'd0);
  endfunction
  function automatic logic m_we();
    return m_fwd() && !m_reported;
  endfunction
  function automatic logic m_ret();
    return m_slot.valid && !m_reported;
  endfunction

  task automatic model_reset();
    m_slot     = '{1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0};
    m_reported = 1'b1;
    m_cnt      = 64'd0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] src, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] rdat, input logic [31:0] pc4,
                       input logic st, input logic fl, input logic clr);
    valid_m = v; reg_write_m = rw; result_src_m = src; rd_m = rd;
    alu_result_m = alu; read_data_m = rdat; pc_plus4_m = pc4;
    stall = st; flush = fl; instret_clr = clr;
  endtask

  // One clock edge: advance the model with the inputs present at the edge
  task automatic step();
    logic ret;
    ret = m_ret();
    if (instret_clr) m_cnt = 64'd0;
    else if (ret)    m_cnt = m_cnt + 64'd1;
    if (flush) begin
      m_slot     = '{1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0};
      m_reported = 1'b1;
    end else if (stall) begin
      m_reported = 1'b1;
    end else begin
      m_slot     = '{valid_m, reg_write_m, result_src_m, rd_m, alu_result_m, read_data_m, pc_plus4_m};
      m_reported = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".we"},      {63'd0, write_en_w},  {63'd0, m_we()});
    chk({tag, ".fwd"},     {63'd0, fwd_valid_w}, {63'd0, m_fwd()});
    chk({tag, ".ret"},     {63'd0, retire_w},    {63'd0, m_ret()});
    chk({tag, ".rd"},      {59'd0, rd_w},        {59'd0, m_slot.rd});
    chk({tag, ".res"},     {32'd0, result_w},    {32'd0, m_result()});
    chk({tag, ".instret"}, instret,              m_cnt);
  endtask

  typedef struct {
    logic        v, rw;
    logic [1:0]  src;
    logic [4:0]  rd;
    logic [31:0] alu, rdat, pc4;
    logic        e_we, e_fwd, e_ret;
    logic [31:0] e_res;
    logic [63:0] e_cnt;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // inputs, then expected we/fwd/ret/result/instret in the cycle after the edge
    vecs[0] = '{1'b1, 1'b1, 2'b00, 5'd5, 32'h0000_00AA, 32'h1, 32'h2, 1'b1, 1'b1, 1'b1, 32'h0000_00AA, 64'd0};
    vecs[1] = '{1'b1, 1'b1, 2'b01, 5'd6, 32'h3, 32'hDEAD_BEEF, 32'h4, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 64'd1};
    vecs[2] = '{1'b1, 1'b1, 2'b10, 5'd1, 32'h5, 32'h6, 32'h0000_0104, 1'b1, 1'b1, 1'b1, 32'h0000_0104, 64'd2};
    vecs[3] = '{1'b1, 1'b1, 2'b11, 5'd3, 32'h55, 32'h66, 32'h77, 1'b1, 1'b1, 1'b1, 32'h0, 64'd3};
    vecs[4] = '{1'b1, 1'b1, 2'b00, 5'd0, 32'h77, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h77, 64'd4};
    vecs[5] = '{1'b0, 1'b1, 2'b00, 5'd9, 32'h88, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h88, 64'd5};
    vecs[6] = '{1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 64'd5};
    vecs[7] = '{1'b1, 1'b0, 2'b00, 5'd4, 32'h99, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h99, 64'd5};
    vecs[8] = '{1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 64'd6};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #2;
    chk("reset.we", {63'd0, write_en_w}, 64'd0);
    chk("reset.fwd", {63'd0, fwd_valid_w}, 64'd0);
    chk("reset.ret", {63'd0, retire_w}, 64'd0);
    chk("reset.rd", {59'd0, rd_w}, 64'd0);
    chk("reset.res", {32'd0, result_w}, 64'd0);
    chk("reset.instret", instret, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].v, vecs[i].rw, vecs[i].src, vecs[i].rd, vecs[i].alu, vecs[i].rdat,
            vecs[i].pc4, 1'b0, 1'b0, 1'b0);
      step();
      chk($sformatf("vec%0d.we", i), {63'd0, write_en_w}, {63'd0, vecs[i].e_we});
      chk($sformatf("vec%0d.fwd", i), {63'd0, fwd_valid_w}, {63'd0, vecs[i].e_fwd});
      chk($sformatf("vec%0d.ret", i), {63'd0, retire_w}, {63'd0, vecs[i].e_ret});
      chk($sformatf("vec%0d.rd", i), {59'd0, rd_w}, {59'd0, vecs[i].rd});
      chk($sformatf("vec%0d.res", i), {32'd0, result_w}, {32'd0, vecs[i].e_res});
      chk($sformatf("vec%0d.instret", i), instret, vecs[i].e_cnt);
    end

    // Stall after capturing rd=7: one write, forwarding held for all four cycles
    drive(1'b1, 1'b1, 2'b00, 5'd7, 32'h1234_5678, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk("stall.c0.we", {63'd0, write_en_w}, 64'd1);
    chk("stall.c0.fwd", {63'd0, fwd_valid_w}, 64'd1);
    chk("stall.c0.res", {32'd0, result_w}, 64'h1234_5678);
    for (int c = 1; c <= 3; c++) begin
      drive(1'b1, 1'b1, 2'b00, 5'd12, 32'hBAD0_BAD0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      step();
      chk($sformatf("stall.c%0d.we", c), {63'd0, write_en_w}, 64'd0);
      chk($sformatf("stall.c%0d.fwd", c), {63'd0, fwd_valid_w}, 64'd1);
      chk($sformatf("stall.c%0d.rd", c), {59'd0, rd_w}, 64'd7);
      chk($sformatf("stall.c%0d.res", c), {32'd0, result_w}, 64'h1234_5678);
      chk($sformatf("stall.c%0d.instret", c), instret, 64'd7);
    end

    // Flush together with stall while W holds a live op
    drive(1'b1, 1'b1, 2'b00, 5'd13, 32'hFFFF_0000, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    step();
    chk("flush.we", {63'd0, write_en_w}, 64'd0);
    chk("flush.fwd", {63'd0, fwd_valid_w}, 64'd0);
    chk("flush.ret", {63'd0, retire_w}, 64'd0);
    chk("flush.res", {32'd0, result_w}, 64'd0);
    chk("flush.rd", {59'd0, rd_w}, 64'd0);

    // Clear on the same edge as a retirement: that retirement is lost
    drive(1'b1, 1'b1, 2'b00, 5'd2, 32'h42, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk("clr.ret", {63'd0, retire_w}, 64'd1);
    drive(1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    step();
    chk("clr.instret0", instret, 64'd0);
    drive(1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    step();
    chk("clr.instret1", instret, 64'd0);

    // Reset asserted mid-stall drops the held instruction immediately
    drive(1'b1, 1'b1, 2'b01, 5'd10, 32'h0, 32'h99, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
    step();
    chk("rststall.fwd_before", {63'd0, fwd_valid_w}, 64'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("rststall.during");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_all("rststall.after");
    chk("rststall.we_after", {63'd0, write_en_w}, 64'd0);
    chk("rststall.instret_after", instret, 64'd0);

    // Wrap-around on the 3-bit counter instance
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b1, 2'b00, 5'(k + 1), 32'(k), 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      step();
    end
    chk("wrap.small7", {61'd0, s_instret}, 64'd7);
    drive(1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    step();
    chk("wrap.small0", {61'd0, s_instret}, 64'd0);
    check_all("wrap.main");

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
            5'($urandom_range(0, 31)), $urandom, $urandom, $urandom,
            $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0);
      step();
      check_all($sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the five-stage RISC-V pipeline: holds the MEM/WB pipeline register, selects the final result, and drives the register-file write port (`WriteEn`, `a3`, `wd3`) that the decode stage consumes. It also exports forwarding data for the execute stage and keeps a 64-bit retired-instruction counter. Stall, flush and bubble handling make it the write-side counterpart of the decode stage's register read.

## Interface
Parameters:
- XLEN, 32, datapath width
- CNT_W, 64, retired-instruction counter width

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold W register contents
- flush  in  1  load a bubble into W
- valid_m  in  1  MEM slot holds a real instruction
- reg_write_m  in  1  instruction writes rd
- result_src_m  in  2  00 ALU, 01 load data, 10 PC+4, 11 reserved
- rd_m  in  5  destination register
- alu_result_m  in  XLEN  ALU result
- read_data_m  in  XLEN  load data from data memory
- pc_plus4_m  in  XLEN  PC+4 for JAL/JALR link
- instret_clr  in  1  synchronous counter clear
- write_en_w  out  1  register-file write enable
- rd_w  out  5  register-file write address
- result_w  out  XLEN  register-file write data
- fwd_valid_w  out  1  W holds a live, writing instruction (forwarding qualifier)
- retire_w  out  1  one-cycle pulse per retired instruction
- instret  out  CNT_W  retired-instruction count

## Operation
- Internal W register fields: valid, reg_write, result_src, rd, alu_result, read_data, pc_plus4, plus a `fresh` bit.
- Capture on each rising clk edge, in priority order:
  - flush: valid←0, reg_write←0, fresh←0. Data fields don't-care and must be cleared to 0.
  - else stall: all fields hold, fresh←0.
  - else: load all `_m` inputs, fresh←1.
- Result mux, combinational from W fields:
  - 00 → alu_result
  - 01 → read_data
  - 10 → pc_plus4
  - 11 → 0
- `rd_w` = W.rd.
- `fwd_valid_w` = valid & reg_write & (rd≠0). It stays asserted while stalled, so held data keeps forwarding.
- `write_en_w` = fwd_valid_w & fresh. Each instruction writes exactly once, even if W is stalled afterwards.
- x0 writes are always suppressed (`write_en_w`=0). `retire_w` still pulses.
- `retire_w` = valid & fresh. One pulse per instruction, regardless of reg_write, so stores and branches are counted.
- instret:
  - instret_clr wins over increment: next value 0.
  - else +1 on each edge where retire_w=1.
  - Wraps from 2^CNT_W−1 to 0 with no flag.

## Timing
- Latency: `_m` inputs captured at edge N. `result_w`, `write_en_w` and `retire_w` are valid in cycle N (after edge N, before N+1).
- The regfile commits on edge N+1.
- The decode stage must resolve the same-cycle read-after-write itself (write-first regfile or bypass). This block does not delay or repeat the write.
- instret reflects a retirement one edge after the `retire_w` pulse.
- Reset (rst_n=0, asynchronous, immediate):
  - all W fields 0, fresh=0
  - write_en_w=0, fwd_valid_w=0, retire_w=0
  - rd_w=0, result_w=0, instret=0
- Reset mid-stall or mid-write drops the in-flight instruction: no write and no count.
- First capture is possible on the first rising edge after rst_n deasserts.
- Simultaneous events:
  - flush+stall behaves as flush.
  - stall with valid_m=1 does not capture: the upstream stage must hold its values.
  - instret_clr coinciding with a retire edge gives instret=0; that retirement is not counted.
- A bubble (valid_m=0) captured normally gives fresh=1 but retire_w=0 and write_en_w=0.
- No combinational path from any `_m` input to any output.

## Test plan
- Reset then ALU op:
  - Stimulus: valid_m=1, reg_write_m=1, result_src_m=00, rd_m=5, alu_result_m=0x0000_00AA.
  - Response after one edge: write_en_w=1, rd_w=5, result_w=0xAA, retire_w=1. Next cycle with a bubble in: instret=1.
- Result select:
  - Load with read_data_m=0xDEAD_BEEF, src=01 → result_w=0xDEADBEEF.
  - JAL with pc_plus4_m=0x104, src=10 → result_w=0x104.
  - src=11 → result_w=0.
- x0 suppression: rd_m=0, reg_write_m=1 → write_en_w=0, fwd_valid_w=0, retire_w=1, instret increments.
- Stall after capture of rd=7, 3 stall cycles:
  - write_en_w=1 for the first cycle only.
  - fwd_valid_w=1 and result_w stable for all 4 cycles.
  - instret increments by exactly 1.
- Flush+stall together with W holding a valid op → next cycle valid=0, write_en_w=0, fwd_valid_w=0, result_w=0.
- Counter boundary:
  - Force instret to 2^64−1, retire one instruction → instret=0.
  - Assert instret_clr on the same edge as a retirement → instret=0.
  - Assert rst_n low mid-stall → all outputs 0 immediately, no write after release.
